wrf_frame_gen: RTL

WRF_FRAME_GEN -- requirements
Module: wrf_frame_gen

---
 rtl/wr_fabric_pkg.sv | 25 ++
 rtl/wrf_frame_gen_word.sv | 43 ++++
 rtl/wrf_frame_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wr_fabric_pkg.sv
// Shared WR fabric definitions: address codes, frame length limits and the
// frame generator state type.
package wr_fabric_pkg;

  localparam logic [1:0]  c_WRF_DATA   = 2'b00;
  localparam logic [1:0]  c_WRF_STATUS = 2'b10;

  localparam logic [10:0] c_MIN_LEN = 11'd60;
  localparam logic [10:0] c_MAX_LEN = 11'd1514;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STATUS,
    ST_DATA,
    ST_FLUSH,
    ST_GAP
  } gen_state_t;

  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    if (len < c_MIN_LEN) return c_MIN_LEN;
    else if (len > c_MAX_LEN) return c_MAX_LEN;
    else return len;
  endfunction

endpackage

// File: rtl/wrf_frame_gen_word.sv
// Combinational frame word generator: maps a data word index to its 16-bit
// big-endian contents (broadcast dst, src MAC, EtherType, seq, payload).
module wrf_frame_gen_word
  import wr_fabric_pkg::*;
#(
  parameter logic [47:0] g_src_mac   = 48'h0050C2000001,
  parameter logic [15:0] g_ethertype = 16'hDBFF
) (
  input  logic [9:0]  word_idx,
  input  logic [10:0] len,
  input  logic [15:0] seq,
  output logic [15:0] dat,
  output logic [1:0]  sel,
  output logic        last
);

  logic [7:0] pay_hi;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    dat    = 16'h0000;
    sel    = 2'b11;
    // Payload starts at byte 16, so the high byte of word w is payload byte 2w-16.
    pay_hi = {word_idx[6:0], 1'b0} - 8'd16;
    last   = ({1'b0, word_idx} == (((len + 11'd1) >> 1) - 11'd1));

    unique case (word_idx)
      10'd0, 10'd1, 10'd2: dat = 16'hFFFF;
      10'd3:               dat = g_src_mac[47:32];
      10'd4:               dat = g_src_mac[31:16];
      10'd5:               dat = g_src_mac[15:0];
      10'd6:               dat = g_ethertype;
      10'd7:               dat = seq;
      default:             dat = {pay_hi, pay_hi + 8'd1};
    endcase

    if (last && len[0]) begin
      dat[7:0] = 8'h00;
      sel      = 2'b10;
    end
  end

endmodule

// File: rtl/wrf_frame_gen.sv
// WR fabric test-frame generator: emits runs of Ethernet frames on a
// pipelined fabric source, with inter-frame gap, stop and error abort.
module wrf_frame_gen
  import wr_fabric_pkg::*;
#(
  parameter logic [47:0] g_src_mac   = 48'h0050C2000001,
  parameter logic [15:0] g_ethertype = 16'hDBFF
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  output logic        src_cyc_o,
  output logic        src_stb_o,
  output logic        src_we_o,
  output logic [1:0]  src_adr_o,
  output logic [1:0]  src_sel_o,
  output logic [15:0] src_dat_o,
  input  logic        src_ack_i,
  input  logic        src_stall_i,
  input  logic        src_err_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [10:0] len_i,
  input  logic [15:0] gap_i,
  input  logic [15:0] count_i,
  output logic        busy_o,
  output logic        done_p_o,
  output logic [31:0] sent_cnt_o,
  output logic [15:0] err_cnt_o
);

  gen_state_t  state, state_nxt;
  logic [10:0] len_q;
  logic [15:0] gap_q, count_q, gap_cnt, seq_q;
  logic [9:0]  word_idx, outst, outst_nxt;
  logic        stop_pend;
  logic [15:0] word_dat;
  logic [1:0]  word_sel;
  logic        word_last;
  logic        accept, abort, ack_v, flush_done, gap_last, run_done;

  wrf_frame_gen_word #(
    .g_src_mac  (g_src_mac),
    .g_ethertype(g_ethertype)
  ) u_word (
    .word_idx(word_idx),
    .len     (len_q),
    .seq     (seq_q),
    .dat     (word_dat),
    .sel     (word_sel),
    .last    (word_last)
  );

  // Fabric strobes decode straight from state so reset drops them asynchronously.
  always_comb begin
    src_cyc_o = (state == ST_STATUS) || (state == ST_DATA) || (state == ST_FLUSH);
    src_stb_o = (state == ST_STATUS) || (state == ST_DATA);
    src_we_o  = src_cyc_o;
    busy_o    = (state != ST_IDLE);
    src_adr_o = c_WRF_DATA;
    src_sel_o = 2'b00;
    src_dat_o = 16'h0000;
    if (state == ST_STATUS) begin
      src_adr_o = c_WRF_STATUS;
      src_sel_o = 2'b11;
    end else if (state == ST_DATA) begin
      src_sel_o = word_sel;
      src_dat_o = word_dat;
    end
  end

  assign accept = src_stb_o && !src_stall_i;
  assign abort  = src_cyc_o && src_err_i;
  assign ack_v  = src_cyc_o && src_ack_i && ((outst != '0) || accept);

  always_comb begin
    outst_nxt = outst;
    if (accept && !ack_v)      outst_nxt = outst + 10'd1;
    else if (!accept && ack_v) outst_nxt = outst - 10'd1;
  end

  assign flush_done = (outst_nxt == '0);
  assign gap_last   = (gap_q == '0) || (gap_cnt == gap_q - 16'd1);
  assign run_done   = stop_pend || ((count_q != '0) && (sent_cnt_o == {16'h0000, count_q}));

  always_comb begin
    state_nxt = state;
    done_p_o  = 1'b0;
    unique case (state)
      ST_IDLE:   if (start_i) state_nxt = ST_STATUS;
      ST_STATUS: if (abort) state_nxt = ST_GAP;
                 else if (accept) state_nxt = ST_DATA;
      ST_DATA:   if (abort) state_nxt = ST_GAP;
                 else if (accept && word_last) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (abort || flush_done) state_nxt = ST_GAP;
      ST_GAP:    if (gap_last) begin
                   if (run_done) begin
                     state_nxt = ST_IDLE;
                     done_p_o  = 1'b1;
                   end else begin
                     state_nxt = ST_STATUS;
                   end
                 end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      gap_q      <= '0;
      count_q    <= '0;
      gap_cnt    <= '0;
      seq_q      <= '0;
      word_idx   <= '0;
      outst      <= '0;
      stop_pend  <= 1'b0;
      sent_cnt_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && start_i) begin
        len_q      <= clamp_len(len_i);
        gap_q      <= gap_i;
        count_q    <= count_i;
        sent_cnt_o <= '0;
      end

      // A stop only marks the run; it is acted on when GAP ends.
      if (state_nxt == ST_IDLE)             stop_pend <= 1'b0;
      else if (stop_i && state != ST_IDLE)  stop_pend <= 1'b1;

      if (state != ST_DATA)  word_idx <= '0;
      else if (accept)       word_idx <= word_idx + 10'd1;

      outst   <= (abort || !src_cyc_o) ? '0 : outst_nxt;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : '0;

      if (abort) begin
        if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
      end else if (state == ST_FLUSH && flush_done) begin
        sent_cnt_o <= sent_cnt_o + 32'd1;
        seq_q      <= seq_q + 16'd1;
      end
    end
  end

endmodule
